// File: rtl/out_port_pkg.sv
// Shared definitions for the processor output-port reader.
//   DATA_W : width of the processor output port and of every buffered byte.
//   word_t : one captured output-port byte.
//   ptr_inc: wrapping pointer increment used by the capture buffer.
package out_port_pkg;

  localparam int DATA_W = 8;

  typedef logic [DATA_W-1:0] word_t;

  // Pointers are $clog2(DEPTH) bits wide with DEPTH a power of two,
  // so plain binary overflow gives the modulo-DEPTH wrap.
  function automatic logic [7:0] ptr_inc(input logic [7:0] ptr);
    ptr_inc = ptr + 8'd1;
  endfunction

endpackage

// File: rtl/out_port_fifo.sv
// First-word-fall-through capture buffer for the output-port reader.
// The caller guarantees push is only asserted when there is room (or a
// pop happens in the same cycle) and pop only when rd_valid is high.
// Ports:
//   clk      : system clock, all state on the rising edge
//   reset    : synchronous, active-low; clears pointers and level
//   push     : write wdata at the tail this cycle
//   wdata    : byte to store
//   pop      : retire the head entry this cycle
//   rd_data  : head entry, 8'h00 when empty (registered)
//   rd_valid : buffer holds at least one byte (registered)
//   level    : number of buffered bytes (registered)
//   full     : level equals DEPTH (registered)
module out_port_fifo
  import out_port_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  word_t                  wdata,
  input  logic                   pop,
  output word_t                  rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] level,
  output logic                   full
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  word_t          mem_r [DEPTH];
  logic [PW-1:0]  wptr_r;
  logic [PW-1:0]  rptr_r;
  logic [PW-1:0]  wptr_s;
  logic [PW-1:0]  rptr_s;
  logic [LW-1:0]  level_r;
  logic [LW-1:0]  level_s;
  word_t          head_s;
  word_t          rd_data_r;
  logic           rd_valid_r;
  logic           full_r;
  logic [7:0]     wptr_inc_s;
  logic [7:0]     rptr_inc_s;

  assign wptr_inc_s = ptr_inc(8'(wptr_r));
  assign rptr_inc_s = ptr_inc(8'(rptr_r));

  // Next-state for pointers, level and the head byte shown after the edge.
  always_comb begin
    wptr_s  = wptr_r;
    rptr_s  = rptr_r;
    level_s = level_r;
    head_s  = {DATA_W{1'b0}};

    if (push) begin
      wptr_s = wptr_inc_s[PW-1:0];
    end else begin
      wptr_s = wptr_r;
    end

    if (pop) begin
      rptr_s = rptr_inc_s[PW-1:0];
    end else begin
      rptr_s = rptr_r;
    end

    if (push && !pop) begin
      level_s = level_r + LW'(1'b1);
    end else if (pop && !push) begin
      level_s = level_r - LW'(1'b1);
    end else begin
      level_s = level_r;
    end

    // The head is registered, so a byte written this cycle that becomes
    // the sole entry must be forwarded from wdata instead of mem_r.
    if (level_s == {LW{1'b0}}) begin
      head_s = {DATA_W{1'b0}};
    end else if (push && (level_s == LW'(1'b1))) begin
      head_s = wdata;
    end else begin
      head_s = mem_r[rptr_s];
    end
  end

  // Storage array; contents need no reset because pointers gate their use.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_r[wptr_r] <= wdata;
    end
  end

  // Control state and registered read-side outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr_r     <= {PW{1'b0}};
      rptr_r     <= {PW{1'b0}};
      level_r    <= {LW{1'b0}};
      rd_data_r  <= {DATA_W{1'b0}};
      rd_valid_r <= 1'b0;
      full_r     <= 1'b0;
    end else begin
      wptr_r     <= wptr_s;
      rptr_r     <= rptr_s;
      level_r    <= level_s;
      rd_data_r  <= head_s;
      rd_valid_r <= (level_s != {LW{1'b0}});
      full_r     <= (level_s == LW'(DEPTH));
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign level    = level_r;
  assign full     = full_r;

endmodule

// File: rtl/out_port_reader.sv
// Captures processor output-port strobes into a small FWFT buffer that a
// consumer drains with a valid/ready handshake. Strobes arriving while the
// buffer is full (and not being popped) are dropped and flagged in a sticky
// overflow bit.
// Optional feature: define OUT_PORT_READER_DEDUP_EN to drop strobes whose
// value equals the most recently captured byte (silently, no overflow).
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-low; discards all buffered bytes
//   outPort  : processor output-port value
//   outLoad  : processor strobe, outPort valid this cycle
//   rd_data  : head-of-buffer byte, 8'h00 when empty
//   rd_valid : rd_data holds a captured byte
//   rd_ready : consumer accepts rd_data this cycle
//   level    : number of buffered bytes
//   overflow : sticky, a strobe was dropped for lack of room
module out_port_reader
  import out_port_pkg::*;
#(
  parameter int DEPTH = 4
)
(
  input  logic                   clk,
  input  logic                   reset,
  input  word_t                  outPort,
  input  logic                   outLoad,
  output word_t                  rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);

  logic pop_s;
  logic push_s;
  logic dup_s;
  logic room_s;
  logic full_s;
  logic overflow_r;

`ifdef OUT_PORT_READER_DEDUP_EN
  word_t last_r;
  logic  last_valid_r;
`endif

  // Strobe acceptance: duplicates are filtered before the room check so a
  // duplicate arriving while full never counts as an overflow.
  always_comb begin
    pop_s  = rd_valid && rd_ready;
`ifdef OUT_PORT_READER_DEDUP_EN
    dup_s  = last_valid_r && (outPort == last_r);
`else
    dup_s  = 1'b0;
`endif
    room_s = !full_s || pop_s;
    push_s = outLoad && !dup_s && room_s;
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      overflow_r <= 1'b0;
    end else if (outLoad && !dup_s && !room_s) begin
      overflow_r <= 1'b1;
    end else begin
      overflow_r <= overflow_r;
    end
  end

`ifdef OUT_PORT_READER_DEDUP_EN
  // Last captured value; the valid flag lets the first strobe after reset
  // through regardless of its value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      last_r       <= {DATA_W{1'b0}};
      last_valid_r <= 1'b0;
    end else if (push_s) begin
      last_r       <= outPort;
      last_valid_r <= 1'b1;
    end else begin
      last_r       <= last_r;
      last_valid_r <= last_valid_r;
    end
  end
`endif

  out_port_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push_s),
    .wdata    (outPort),
    .pop      (pop_s),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .level    (level),
    .full     (full_s)
  );

  assign overflow = overflow_r;

endmodule

// File: tb/tb_out_port_reader.sv
// Randomized and directed bench for out_port_reader. A queue-based model
// predicts buffer contents; bytes the model expects to be popped go into a
// scoreboard queue that an independent monitor checks at each handshake.
module tb_out_port_reader;
  import out_port_pkg::*;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk      = 1'b0;
  logic          reset    = 1'b0;
  logic          outLoad  = 1'b0;
  logic          rd_ready = 1'b0;
  word_t         outPort  = 8'h00;
  word_t         rd_data;
  logic          rd_valid;
  logic          overflow;
  logic [LW-1:0] level;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_q[$];
  logic [7:0] exp_q[$];
  bit         m_ovf    = 1'b0;
  bit         m_last_v = 1'b0;
  logic [7:0] m_last   = 8'h00;

  always #5 clk = ~clk;

  out_port_reader #(.DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .outPort  (outPort),
    .outLoad  (outLoad),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .level    (level),
    .overflow (overflow)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare observable state against the model (called at a falling edge).
  task automatic check_state();
    int n;
    n = model_q.size();
    chk("level", int'(level), n);
    chk("rd_valid", int'(rd_valid), (n != 0) ? 1 : 0);
    chk("overflow", int'(overflow), int'(m_ovf));
    chk("rd_data", int'(rd_data), (n != 0) ? int'(model_q[0]) : 0);
  endtask

  // One cycle: check, drive inputs for the next rising edge, advance model.
  task automatic step(input bit ld, input logic [7:0] d, input bit rdy, input bit rs);
    bit pop;
    bit room;
    bit dup;
    @(negedge clk);
    check_state();
    outLoad  = ld;
    outPort  = d;
    rd_ready = rdy;
    reset    = rs;
    if (!rs) begin
      model_q.delete();
      m_ovf    = 1'b0;
      m_last_v = 1'b0;
    end else begin
      pop  = rdy && (model_q.size() != 0);
      room = (model_q.size() < DEPTH) || pop;
      dup  = 1'b0;
`ifdef OUT_PORT_READER_DEDUP_EN
      dup  = m_last_v && (d == m_last);
`endif
      if (pop) exp_q.push_back(model_q.pop_front());
      if (ld && !dup) begin
        if (room) begin
          model_q.push_back(d);
          m_last   = d;
          m_last_v = 1'b1;
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b1);
  endtask

  task automatic drain(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // Scoreboard monitor: every DUT handshake must deliver the next expected byte.
  always @(posedge clk) begin
    if (reset && rd_valid && rd_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none at %0t", rd_data, $time);
      end else begin
        chk("pop_data", int'(rd_data), int'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    reset = 1'b0;
    repeat (2) @(negedge clk);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Single strobe held with rd_ready low.
    step(1'b1, 8'h37, 1'b0, 1'b1);
    idle();
    chk("single_data", int'(rd_data), 8'h37);
    chk("single_level", int'(level), 1);
    repeat (5) idle();
    chk("single_hold", int'(rd_data), 8'h37);
    drain(1);
    idle();

    // Four strobes then back-to-back pops.
    for (int i = 1; i <= 4; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    drain(4);
    idle();
    chk("drain_valid", int'(rd_valid), 0);
    chk("drain_data", int'(rd_data), 8'h00);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Overflow when full without a pop; sticky after draining.
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0, 1'b1);
    step(1'b1, 8'hAA, 1'b0, 1'b1);
    idle();
    chk("ovf_set", int'(overflow), 1);
    chk("ovf_level", int'(level), 4);
    drain(4);
    idle();
    chk("ovf_sticky", int'(overflow), 1);
    step(1'b0, 8'h00, 1'b0, 1'b0);

    // Full buffer with simultaneous pop accepts the new byte.
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h22, 1'b0, 1'b1);
    step(1'b1, 8'h33, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b0, 1'b1);
    step(1'b1, 8'h55, 1'b1, 1'b1);
    idle();
    chk("full_pop_level", int'(level), 4);
    chk("full_pop_ovf", int'(overflow), 0);
    drain(3);
    idle();
    chk("last_is_55", int'(rd_data), 8'h55);
    drain(1);

    // Reset mid-operation with a strobe present.
    step(1'b1, 8'h61, 1'b0, 1'b1);
    step(1'b1, 8'h62, 1'b0, 1'b1);
    step(1'b1, 8'h63, 1'b0, 1'b1);
    step(1'b1, 8'h99, 1'b0, 1'b0);
    idle();
    chk("rst_level", int'(level), 0);
    chk("rst_valid", int'(rd_valid), 0);
    chk("rst_ovf", int'(overflow), 0);

`ifdef OUT_PORT_READER_DEDUP_EN
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b1);
    step(1'b1, 8'h11, 1'b0, 1'b1);
    step(1'b1, 8'h10, 1'b0, 1'b1);
    idle();
    chk("dedup_level", int'(level), 3);
    chk("dedup_ovf", int'(overflow), 0);
    drain(3);
    step(1'b0, 8'h00, 1'b0, 1'b0);
`endif

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 99) < 60) ? 1'b1 : 1'b0,
           8'($urandom_range(0, 7)),
           ($urandom_range(0, 99) < 45) ? 1'b1 : 1'b0,
           ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1);
    end

    drain(DEPTH + 1);
    @(negedge clk);
    check_state();
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
